data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
//
// PURPOSE
//   Two-requester arbiter/stall controller in front of the single-port data
//   memory of processor_system. Port m0 is the core LSU, port m1 an auxiliary
//   master (DMA/debug). Grants memory access round-robin and generates
//   per-port stall so each master sees the core stall protocol: stall high
//   while pending, low for exactly the completion cycle.
//
// PARAMETERS
//   ADDR_W   32   address width, bits
//   DATA_W   32   data width, bits; byte-enable width is DATA_W/8
//
// PORTS
//   clk_i           in   1         system clock, single clock domain
//   rst_i           in   1         synchronous reset, active-high
//   mX_req_i        in   1         request from master X (X = 0, 1)
//   mX_we_i         in   1         1 = write, 0 = read
//   mX_addr_i       in   ADDR_W    byte address
//   mX_wdata_i      in   DATA_W    write data
//   mX_be_i         in   DATA_W/8  byte enables
//   mX_stall_o      out  1         1 = hold request stable, not complete
//   mX_rdata_o      out  DATA_W    read data, valid when req & !stall
//   mem_req_o       out  1         memory access strobe
//   mem_we_o        out  1         memory write enable
//   mem_addr_o      out  ADDR_W    memory address
//   mem_wdata_o     out  DATA_W    memory write data
//   mem_be_o        out  DATA_W/8  memory byte enables
//   mem_rdata_i     in   DATA_W    memory read data, 1 cycle after mem_req_o
//
// BEHAVIOUR
// - Memory: synchronous, issue in cycle N, rdata valid in cycle N+1.
// - Master contract: req and all fields stable while stall_o=1; transaction
//   completes in the cycle req=1 and stall_o=0; may drop or re-raise req
//   after completion.
// - FSM (registered): IDLE, BUSY0, BUSY1. BUSYx = access of master x issued
//   last cycle, completing now. Reset state IDLE; rr_q (round-robin) resets
//   to 0.
// - Grant (combinational):
//     IDLE : req0 & req1 -> grant per rr_q (0: m0, 1: m1); one req -> it.
//     BUSY0: grant m1 if m1_req_i, else none (m0 never back-to-back).
//     BUSY1: grant m0 if m0_req_i, else none.
// - Next state: grant to x -> BUSYx; no grant -> IDLE.
// - rr_q <= ~x on each grant to x (other master wins next IDLE tie).
// - mem_* outputs: fields of granted master in the grant cycle; no grant ->
//   mem_req_o=0, mem_we_o=0, addr/wdata/be=0.
// - mX_stall_o = mX_req_i & (state != BUSYx). Unrequested port: stall 0.
// - mX_rdata_o = mem_rdata_i (broadcast); meaningful only in completion cycle.
// - Latency: uncontended = 2 cycles (stall 1 cycle, then 0). Contended loser:
//   +1 cycle per interleaved foreign access; worst case 3 cycles.
// - Both requesting continuously: grants alternate m0,m1,m0,...; mem_req_o
//   high every cycle (issue overlaps other port's completion).
// - Writes take the same 2-cycle path; mem_rdata_i ignored for writes.
// - Reset (any state, incl. BUSYx): state->IDLE, rr_q->0 on next edge; while
//   rst_i=1, no grant (mem_req_o=0, all mem_* = 0), mX_stall_o = mX_req_i; an
//   access issued before reset is dropped, its master does not complete.
// - Any one master: stall never low for 2 consecutive cycles while req held.
//
// TESTING
// 1 Reset: rst_i=1 for 2 cycles, m0_req_i=1 -> mem_req_o=0, m0_stall_o=1;
//   first cycle after release -> mem_req_o=1, mem_addr_o = m0_addr_i.
// 2 m0 read 0x10, memory returns 0xDEADBEEF -> c0: mem_req_o=1, addr 0x10,
//   m0_stall_o=1; c1: m0_stall_o=0, m0_rdata_o=0xDEADBEEF, mem_req_o=0.
// 3 m0,m1 request same cycle after reset -> c0 grant m0; c1 m0 completes and
//   m1 issued; c2 m1 completes; m1_stall_o=1 in c0-c1.
// 4 both req held 10 cycles -> mem_req_o=1 every cycle, grants alternate,
//   each stall_o low every other cycle, never 2 in a row.
// 5 m1 write 0x20 data 0x12345678 be 4'b0011 -> mem_we_o=1, addr 0x20,
//   wdata 0x12345678, be 4'b0011; m1_stall_o=0 next cycle.
// 6 rst_i=1 in BUSY0 -> m0_stall_o stays 1, mem_req_o=0; after release m0
//   re-granted, completes 2 cycles later with fresh mem_rdata_i.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter and stall generator placing two masters
// (m0 = core LSU, m1 = auxiliary DMA/debug) in front of one synchronous
// single-port data memory. Each master sees the core stall protocol: stall is
// high while its access is pending and low for exactly the completion cycle.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_be_i,
  output logic                  m0_stall_o,
  output logic [DATA_W-1:0]     m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_be_i,
  output logic                  m1_stall_o,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  // BUSYx means master x's access was issued last cycle and completes now.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state_r;
  logic   rr_r;
  logic   gnt0_s;
  logic   gnt1_s;

  // Grant selection: a master is never granted in its own completion cycle,
  // which is what makes continuous contention alternate cleanly.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst_i) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_req_i && m1_req_i) begin
            gnt0_s = ~rr_r;
            gnt1_s = rr_r;
          end else begin
            gnt0_s = m0_req_i;
            gnt1_s = m1_req_i;
          end
        end
        BUSY0:   gnt1_s = m1_req_i;
        BUSY1:   gnt0_s = m0_req_i;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // State and round-robin pointer: the master just granted loses the next tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      rr_r    <= 1'b0;
    end else if (gnt0_s) begin
      state_r <= BUSY0;
      rr_r    <= 1'b1;
    end else if (gnt1_s) begin
      state_r <= BUSY1;
      rr_r    <= 1'b0;
    end else begin
      state_r <= IDLE;
    end
  end

  // Memory request mux: granted master's fields, all-zero when nothing issues.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt0_s) begin
      mem_req_o   = 1'b1;
      mem_we_o    = m0_we_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
      mem_be_o    = m0_be_i;
    end else if (gnt1_s) begin
      mem_req_o   = 1'b1;
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_be_o    = m1_be_i;
    end else begin
      mem_req_o   = 1'b0;
    end
  end

  // Stall: low only in the owning master's completion cycle; reset cancels an
  // in-flight completion so the dropped access never appears to finish.
  always_comb begin
    m0_stall_o = m0_req_i & (rst_i | (state_r != BUSY0));
    m1_stall_o = m1_req_i & (rst_i | (state_r != BUSY1));
  end

  // Read data is broadcast; only the completing master samples it.
  always_comb begin
    m0_rdata_o = mem_rdata_i;
    m1_rdata_o = mem_rdata_i;
  end

endmodule
